// File: rtl/troco_dispenser_if.sv
// rtl/troco_dispenser_if.sv - payout request and coin-ejection handshake bundle
interface troco_dispenser_if;
  logic       req;
  logic [3:0] amount;
  logic       refill;
  logic       busy;
  logic [1:0] coin;
  logic       coin_valid;
  logic       coin_ack;
  logic       done;
  logic       short;
  logic [3:0] remaining;

  modport master (
    output req, amount, refill, coin_ack,
    input  busy, coin, coin_valid, done, short, remaining
  );

  modport slave (
    input  req, amount, refill, coin_ack,
    output busy, coin, coin_valid, done, short, remaining
  );
endinterface

// File: rtl/troco_dispenser.sv
// rtl/troco_dispenser.sv - greedy change payout FSM driving a one-coin-at-a-time ejector
// Optional per-denomination coin inventory is enabled by defining TROCO_INVENTORY_EN.
module troco_dispenser #(
  parameter int MAX_UNITS = 15,
  parameter int COIN_GAP  = 2,
  parameter int INV_INIT  = 8
) (
  input logic              clk,
  input logic              reset,
  troco_dispenser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SELECT, OFFER, GAP, DONE} state_t;

  localparam int              GAP_W    = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(COIN_GAP - 1);

  state_t           state, state_n;
  logic [3:0]       rem, rem_n;
  logic [1:0]       coin_q, coin_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [3:0]       remaining_q, remaining_n;
  logic             short_q, short_n;
  logic [3:0]       req_amt;
  logic             has25, has10, has5;

  function automatic logic [3:0] coin_units(input logic [1:0] c);
    case (c)
      2'b11:   coin_units = 4'd5;
      2'b10:   coin_units = 4'd2;
      2'b01:   coin_units = 4'd1;
      default: coin_units = 4'd0;
    endcase
  endfunction

  assign req_amt = ({1'b0, bus.amount} > 5'(MAX_UNITS)) ? 4'(MAX_UNITS) : bus.amount;

`ifdef TROCO_INVENTORY_EN
  logic [7:0] cnt25, cnt10, cnt5;

  assign has25 = (cnt25 != 8'd0);
  assign has10 = (cnt10 != 8'd0);
  assign has5  = (cnt5  != 8'd0);

  // Refill is applied in IDLE before the same-cycle request reaches SELECT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt25 <= 8'(INV_INIT);
      cnt10 <= 8'(INV_INIT);
      cnt5  <= 8'(INV_INIT);
    end else if (state == IDLE && bus.refill) begin
      cnt25 <= 8'(INV_INIT);
      cnt10 <= 8'(INV_INIT);
      cnt5  <= 8'(INV_INIT);
    end else if (state == OFFER && bus.coin_ack) begin
      case (coin_q)
        2'b11:   cnt25 <= cnt25 - 8'd1;
        2'b10:   cnt10 <= cnt10 - 8'd1;
        2'b01:   cnt5  <= cnt5 - 8'd1;
        default: ;
      endcase
    end
  end
`else
  localparam int unused_inv_init = INV_INIT;
  logic unused_refill;

  assign unused_refill = bus.refill;
  assign has25 = 1'b1;
  assign has10 = 1'b1;
  assign has5  = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem         <= 4'd0;
      coin_q      <= 2'b00;
      gap_cnt     <= '0;
      remaining_q <= 4'd0;
      short_q     <= 1'b0;
    end else begin
      rem         <= rem_n;
      coin_q      <= coin_n;
      gap_cnt     <= gap_n;
      remaining_q <= remaining_n;
      short_q     <= short_n;
    end
  end

  always_comb begin
    state_n     = state;
    rem_n       = rem;
    coin_n      = coin_q;
    gap_n       = gap_cnt;
    remaining_n = remaining_q;
    short_n     = short_q;
    case (state)
      IDLE: begin
        if (bus.req) begin
          rem_n       = req_amt;
          remaining_n = 4'd0;
          short_n     = 1'b0;
          state_n     = (req_amt == 4'd0) ? DONE : SELECT;
        end
      end
      SELECT: begin
        // Largest coin that fits and is in stock; none left means a short payout.
        if (rem >= 4'd5 && has25) begin
          coin_n  = 2'b11;
          state_n = OFFER;
        end else if (rem >= 4'd2 && has10) begin
          coin_n  = 2'b10;
          state_n = OFFER;
        end else if (rem != 4'd0 && has5) begin
          coin_n  = 2'b01;
          state_n = OFFER;
        end else begin
          remaining_n = rem;
          short_n     = (rem != 4'd0);
          state_n     = DONE;
        end
      end
      OFFER: begin
        if (bus.coin_ack) begin
          rem_n = rem - coin_units(coin_q);
          if (rem_n == 4'd0) begin
            remaining_n = 4'd0;
            short_n     = 1'b0;
            state_n     = DONE;
          end else if (COIN_GAP == 0) begin
            state_n = SELECT;
          end else begin
            gap_n   = GAP_LAST;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = SELECT;
        else               gap_n   = gap_cnt - 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy       = (state != IDLE);
  assign bus.coin_valid = (state == OFFER);
  assign bus.coin       = (state == OFFER) ? coin_q : 2'b00;
  assign bus.done       = (state == DONE);
  assign bus.short      = short_q;
  assign bus.remaining  = remaining_q;
endmodule

// File: tb/tb_troco_dispenser.sv
// tb/tb_troco_dispenser.sv - vector table, corner sequences and random payouts vs a greedy model
module tb_troco_dispenser;
  localparam int GAP = 2;
  localparam int INV = 1;
`ifdef TROCO_INVENTORY_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  troco_dispenser_if ifc ();
  troco_dispenser_if ifc0 ();

  troco_dispenser #(.MAX_UNITS(15), .COIN_GAP(GAP), .INV_INIT(INV)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );
  troco_dispenser #(.MAX_UNITS(15), .COIN_GAP(0), .INV_INIT(8)) dut0 (
    .clk(clk), .reset(reset), .bus(ifc0)
  );

  typedef struct {
    logic [3:0] amount;
    int         dly;
    logic [5:0] coins;
    int         n;
  } vec_t;

  vec_t tbl[8];
  int nvec = 0;
  int nfail = 0;

  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];
  logic       got_short;
  int         got_rem;
  bit         exp_short;
  int         exp_rem;
  int         inv[3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void inv_reload();
    for (int k = 0; k < 3; k++) inv[k] = INV;
  endfunction

  // Greedy over coin values {1,2,5} units with optional stock limits.
  function automatic void model(input int amt, input bit rf);
    int r;
    bit found;
    int vals[3];
    logic [1:0] codes[3];
    vals  = '{1, 2, 5};
    codes = '{2'b01, 2'b10, 2'b11};
    if (rf) inv_reload();
    r = (amt > 15) ? 15 : amt;
    exp_q.delete();
    while (r > 0) begin
      found = 1'b0;
      for (int k = 2; k >= 0; k--) begin
        if (!found && vals[k] <= r && (!INV_EN || inv[k] > 0)) begin
          exp_q.push_back(codes[k]);
          r = r - vals[k];
          inv[k] = inv[k] - 1;
          found = 1'b1;
        end
      end
      if (!found) break;
    end
    exp_short = (r != 0);
    exp_rem   = r;
  endfunction

  task automatic payout(input logic [3:0] amt, input int dly, input bit rf, input bit jam);
    int cyc;
    int ack_cyc;
    bit fin;
    bit stable;
    logic [1:0] c;
    @(negedge clk);
    ifc.req = 1'b1; ifc.amount = amt; ifc.refill = rf;
    @(negedge clk);
    ifc.refill = 1'b0;
    if (jam) ifc.amount = 4'd7;
    else     ifc.req = 1'b0;
    check("busy_after_req", ifc.busy, 1);
    got_q.delete();
    cyc = 0; fin = 1'b0; ack_cyc = -100;
    while (!fin && cyc < 200) begin
      if (ifc.done) begin
        fin = 1'b1;
        got_short = ifc.short;
        got_rem = int'(ifc.remaining);
        ifc.req = 1'b0;
        if (amt == 4'd0) check("zero_done_cycle", cyc, 0);
        if (got_q.size() > 0)
          check("done_latency", cyc, exp_short ? ack_cyc + 2 + GAP : ack_cyc + 1);
      end else if (ifc.coin_valid) begin
        if (got_q.size() == 0) check("first_offer_cycle", cyc, 1);
        else                   check("coin_spacing", cyc, ack_cyc + 2 + GAP);
        c = ifc.coin;
        got_q.push_back(c);
        stable = 1'b1;
        repeat (dly) begin
          @(negedge clk); cyc++;
          if (ifc.coin !== c || ifc.coin_valid !== 1'b1) stable = 1'b0;
        end
        check("coin_stable", stable, 1);
        ifc.coin_ack = 1'b1; ack_cyc = cyc;
        @(negedge clk); cyc++;
        ifc.coin_ack = 1'b0;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check("done_seen", fin, 1);
    ifc.req = 1'b0;
    @(negedge clk);
    check("busy_after_done", ifc.busy, 0);
  endtask

  task automatic compare_result(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_coin%0d", name, i), got_q[i], exp_q[i]);
    check({name, "_short"}, got_short, exp_short);
    check({name, "_remaining"}, got_rem, exp_rem);
  endtask

  initial begin
    int cyc, prev, n, amt, dly;
    bit fin, rf;

    tbl[0] = '{4'd0, 0, 6'b000000, 0};
    tbl[1] = '{4'd1, 0, 6'b000001, 1};
    tbl[2] = '{4'd2, 1, 6'b000010, 1};
    tbl[3] = '{4'd3, 0, 6'b000110, 2};
    tbl[4] = '{4'd5, 2, 6'b000011, 1};
    tbl[5] = '{4'd6, 0, 6'b000111, 2};
    tbl[6] = '{4'd7, 3, 6'b001011, 2};
    tbl[7] = '{4'd8, 0, 6'b011011, 3};

    reset = 1'b1;
    ifc.req = 1'b0; ifc.amount = 4'd0; ifc.refill = 1'b0; ifc.coin_ack = 1'b0;
    ifc0.req = 1'b0; ifc0.amount = 4'd0; ifc0.refill = 1'b0; ifc0.coin_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {ifc.busy, ifc.coin, ifc.coin_valid, ifc.done, ifc.short, ifc.remaining}, 0);
    reset = 1'b0;
    inv_reload();

    for (int i = 0; i < 8; i++) begin
      model(int'(tbl[i].amount), 1'b1);
      exp_q.delete();
      for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(tbl[i].coins[2*k +: 2]);
      exp_short = 1'b0;
      exp_rem   = 0;
      payout(tbl[i].amount, tbl[i].dly, 1'b1, 1'b0);
      compare_result($sformatf("tbl%0d", i));
    end

    // A second request held high during a busy payout must not start another one.
    model(2, 1'b1);
    payout(4'd2, 0, 1'b1, 1'b1);
    compare_result("req_while_busy");
    repeat (3) @(negedge clk);
    check("idle_after_jam", ifc.busy, 0);

    // Asynchronous reset in the middle of an offer.
    @(negedge clk);
    ifc.req = 1'b1; ifc.amount = 4'd5;
    @(negedge clk);
    ifc.req = 1'b0;
    @(negedge clk);
    check("offer_before_reset", ifc.coin_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("reset_drops_valid", ifc.coin_valid, 0);
    check("reset_drops_busy", ifc.busy, 0);
    check("reset_clears_coin", ifc.coin, 0);
    @(negedge clk);
    reset = 1'b0;
    inv_reload();
    model(1, 1'b0);
    payout(4'd1, 0, 1'b0, 1'b0);
    compare_result("after_reset");

`ifdef TROCO_INVENTORY_EN
    model(11, 1'b1);
    exp_q.delete();
    exp_q.push_back(2'b11); exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    exp_short = 1'b1;
    exp_rem   = 3;
    payout(4'd11, 0, 1'b1, 1'b0);
    compare_result("inv_short");
    @(negedge clk);
    check("remaining_holds", ifc.remaining, 3);
    check("short_holds", ifc.short, 1);
    model(3, 1'b1);
    payout(4'd3, 0, 1'b1, 1'b0);
    compare_result("inv_refill");
`endif

    // Zero-gap instance: three quarters, one every two cycles.
    @(negedge clk);
    ifc0.req = 1'b1; ifc0.amount = 4'd15;
    @(negedge clk);
    ifc0.req = 1'b0;
    cyc = 0; prev = -1; n = 0; fin = 1'b0;
    while (!fin && cyc < 100) begin
      if (ifc0.done) begin
        fin = 1'b1;
        check("gap0_short", ifc0.short, 0);
        check("gap0_remaining", ifc0.remaining, 0);
      end else if (ifc0.coin_valid) begin
        check("gap0_coin", ifc0.coin, 2'b11);
        if (prev >= 0) check("gap0_spacing", cyc - prev, 2);
        prev = cyc; n++;
        ifc0.coin_ack = 1'b1;
        @(negedge clk); cyc++;
        ifc0.coin_ack = 1'b0;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check("gap0_done_seen", fin, 1);
    check("gap0_count", n, 3);

    for (int i = 0; i < 60; i++) begin
      amt = int'($urandom_range(0, 15));
      dly = int'($urandom_range(0, 2));
      rf  = ($urandom_range(0, 3) == 0);
      model(amt, rf);
      payout(4'(amt), dly, rf, 1'b0);
      compare_result($sformatf("rand%0d_amt%0d", i, amt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
